// File: rtl/jtframe_objdma.sv
// Object-table DMA: grabs the CPU bus, copies OBJS*BPO bytes from video RAM into a
// (optionally double-buffered) object buffer, and serves the renderer through a registered read port.
module jtframe_objdma #(
   parameter int OBJS = 128,
   parameter int BPO  = 4,
   parameter int AW   = 9,
   parameter int DW   = 8,
   parameter int DBUF = 1
)(
   input  logic          rst,
   input  logic          clk,
   input  logic          cen,
   input  logic          lvbl,
   input  logic          dma_go,
   output logic          busrq,
   input  logic          busak_n,
   output logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_din,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          busy,
   output logic          done
);

   localparam logic [AW:0] N = (AW+1)'(OBJS*BPO);

   typedef enum logic [1:0] {IDLE, REQ, COPY, REL} state_t;

   state_t        state, state_nx;
   logic [AW:0]   cnt, cnt_m1;
   logic          pending, ready, front, lvbl_l;
   logic          start, step, last, finish, swap, wr_en, wbank;
   logic [AW:0]   wr_idx;
   logic [DW-1:0] mem [0:2**(AW+1)-1];

   assign cnt_m1 = cnt - (AW+1)'(1);
   assign wbank  = (DBUF != 0) ? ~front : 1'b0;
   assign wr_en  = step && (cnt != '0);
   assign wr_idx = {wbank, cnt_m1[AW-1:0]};
   // The swap never happens under an active copy, so the back bank is always complete.
   assign swap   = (DBUF != 0) && lvbl_l && !lvbl && ready && !busy;

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      step     = 1'b0;
      last     = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: if (dma_go || pending) begin
            start    = 1'b1;
            state_nx = REQ;
         end
         REQ:  if (!busak_n) state_nx = COPY;
         COPY: if (cen && !busak_n) begin
            step = 1'b1;
            if (cnt == N) begin
               last     = 1'b1;
               state_nx = REL;
            end
         end
         REL:  if (busak_n) begin
            finish   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busrq    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         dma_addr <= '0;
         cnt      <= '0;
         pending  <= 1'b0;
         ready    <= 1'b0;
         front    <= 1'b0;
         lvbl_l   <= 1'b1;
      end else begin
         lvbl_l <= lvbl;
         done   <= finish;
         if (start) begin
            busrq <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
         end
         if (last)   busrq <= 1'b0;
         if (finish) busy  <= 1'b0;
         if (step) begin
            dma_addr <= cnt[AW-1:0];
            if (!last) cnt <= cnt + (AW+1)'(1);
         end
         // Requests arriving while busy collapse into a single pending one.
         if (start)             pending <= 1'b0;
         else if (dma_go && busy) pending <= 1'b1;
         if (finish) ready <= 1'b1;
         else if (swap) begin
            ready <= 1'b0;
            front <= ~front;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= dma_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[{front, rd_addr}];
   end

endmodule

// File: tb/tb_jtframe_objdma.sv
// Directed bench for jtframe_objdma: default double-buffered geometry plus a
// 32x8 single-bank instance, fed by a CPU bus arbiter model and an addr^key source RAM.
module tb_jtframe_objdma;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] cen_ph = 2'd0;
   logic       cen;

   logic       lvbl0 = 1'b1, go0 = 1'b0, busak_n0 = 1'b1, hold0 = 1'b0;
   logic       busrq0, busy0, done0;
   logic [8:0] dma_addr0, rd_addr0 = 9'd0;
   logic [7:0] dma_din0, rd_data0, key0 = 8'h5A;

   logic       lvbl1 = 1'b1, go1 = 1'b0, busak_n1 = 1'b1;
   logic       busrq1, busy1, done1;
   logic [7:0] dma_addr1, rd_addr1 = 8'd0;
   logic [7:0] dma_din1, rd_data1, key1 = 8'hC3;

   int tests = 0, fails = 0;
   int acks0 = 0, acks1 = 0, done_cnt0 = 0, done_cnt1 = 0, rises0 = 0;
   logic rq_prev0 = 1'b0;
   int a, r;
   logic [8:0] addr_hold;

   always #5 clk = ~clk;

   always @(posedge clk) cen_ph <= (cen_ph == 2'd2) ? 2'd0 : cen_ph + 2'd1;
   assign cen = (cen_ph == 2'd0);

   assign dma_din0 = dma_addr0[7:0] ^ key0;
   assign dma_din1 = dma_addr1 ^ key1;

   jtframe_objdma u0 (
      .rst(rst), .clk(clk), .cen(cen), .lvbl(lvbl0), .dma_go(go0),
      .busrq(busrq0), .busak_n(busak_n0), .dma_addr(dma_addr0), .dma_din(dma_din0),
      .rd_addr(rd_addr0), .rd_data(rd_data0), .busy(busy0), .done(done0)
   );

   jtframe_objdma #(.OBJS(32), .BPO(8), .AW(8), .DW(8), .DBUF(0)) u1 (
      .rst(rst), .clk(clk), .cen(cen), .lvbl(lvbl1), .dma_go(go1),
      .busrq(busrq1), .busak_n(busak_n1), .dma_addr(dma_addr1), .dma_din(dma_din1),
      .rd_addr(rd_addr1), .rd_data(rd_data1), .busy(busy1), .done(done1)
   );

   // CPU arbiter: grants only right after a cen edge, releases when busrq drops.
   always @(posedge clk) begin
      #2;
      if (rst || !busrq0 || hold0) busak_n0 = 1'b1;
      else if (cen_ph == 2'd1)     busak_n0 = 1'b0;
      if (rst || !busrq1)          busak_n1 = 1'b1;
      else if (cen_ph == 2'd1)     busak_n1 = 1'b0;
   end

   always @(posedge clk) begin
      if (cen && !busak_n0 && busrq0) acks0++;
      if (cen && !busak_n1 && busrq1) acks1++;
      if (done0) done_cnt0++;
      if (done1) done_cnt1++;
      if (busrq0 && !rq_prev0) rises0++;
      rq_prev0 = busrq0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_go0();
      go0 = 1'b1;
      tick(1);
      go0 = 1'b0;
   endtask

   task automatic pulse_go1();
      go1 = 1'b1;
      tick(1);
      go1 = 1'b0;
   endtask

   task automatic wait_done0(input int target, input int budget, input string tag);
      int n = 0;
      while (done_cnt0 < target && n < budget) begin tick(1); n++; end
      check(tag, done_cnt0, target);
   endtask

   task automatic wait_done1(input int target, input int budget, input string tag);
      int n = 0;
      while (done_cnt1 < target && n < budget) begin tick(1); n++; end
      check(tag, done_cnt1, target);
   endtask

   task automatic wait_addr0(input logic [8:0] value, input int budget, input string tag);
      int n = 0;
      while (dma_addr0 != value && n < budget) begin tick(1); n++; end
      check(tag, dma_addr0, value);
   endtask

   task automatic vblank0();
      lvbl0 = 1'b0;
      tick(2);
   endtask

   task automatic check_bank0(input logic [7:0] key, input string tag);
      for (int k = 0; k < 512; k++) begin
         logic [8:0] ka;
         ka = 9'(k);
         rd_addr0 = ka;
         tick(1);
         check(tag, rd_data0, ka[7:0] ^ key);
      end
   endtask

   initial begin
      tick(3);
      check("rst_busrq0", busrq0, 1'b0);
      check("rst_busy0", busy0, 1'b0);
      check("rst_done0", done0, 1'b0);
      check("rst_addr0", dma_addr0, 9'd0);
      check("rst_rd0", rd_data0, 8'd0);
      check("rst_busrq1", busrq1, 1'b0);
      check("rst_rd1", rd_data1, 8'd0);
      rst = 1'b0;
      tick(2);

      // Copy A into bank 1, then swap at vblank
      key0 = 8'h5A; a = acks0;
      pulse_go0();
      check("busy_on_a", busy0, 1'b1);
      wait_done0(1, 3000, "done_a");
      check("acks_a", acks0 - a, 513);
      check("busrq_off_a", busrq0, 1'b0);
      check("busy_off_a", busy0, 1'b0);
      tick(20);
      check("done_once_a", done_cnt0, 1);
      rd_addr0 = 9'h1F3;
      tick(1);
      vblank0();
      check("swap_a_1f3", rd_data0, 8'hA9);
      lvbl0 = 1'b1;
      check_bank0(8'h5A, "bank_a");

      // Copy B with a 10-cen bus pause at address 100
      key0 = 8'h33; a = acks0;
      pulse_go0();
      wait_addr0(9'd100, 1000, "reach_100");
      hold0 = 1'b1;
      tick(2);
      addr_hold = dma_addr0;
      for (int n = 0; n < 10; ) begin
         @(posedge clk);
         if (cen) n++;
      end
      #1;
      check("pause_addr", dma_addr0, addr_hold);
      check("pause_busrq", busrq0, 1'b1);
      hold0 = 1'b0;
      wait_done0(2, 3000, "done_b");
      check("acks_b", acks0 - a, 513);
      rd_addr0 = 9'h1F3;
      tick(1);
      check("old_front_b", rd_data0, 8'hA9);
      vblank0();
      check("swap_b_1f3", rd_data0, 8'hC0);
      lvbl0 = 1'b1;
      check_bank0(8'h33, "bank_b");

      // Copy C with two extra requests merged into one pending copy
      key0 = 8'h77; a = acks0; r = rises0;
      pulse_go0();
      wait_addr0(9'd20, 1000, "reach_20");
      pulse_go0();
      tick(30);
      pulse_go0();
      wait_done0(4, 8000, "done_c");
      check("acks_c", acks0 - a, 1026);
      check("rises_c", rises0 - r, 2);
      tick(300);
      check("no_third_c", done_cnt0, 4);
      check("idle_c", busy0, 1'b0);
      rd_addr0 = 9'h1F3;
      tick(1);
      check("old_front_c", rd_data0, 8'hC0);
      vblank0();
      check("swap_c_1f3", rd_data0, 8'h84);
      lvbl0 = 1'b1;
      rd_addr0 = 9'h000; tick(1); check("bank_c_000", rd_data0, 8'h77);
      rd_addr0 = 9'h100; tick(1); check("bank_c_100", rd_data0, 8'h77);
      rd_addr0 = 9'h1FF; tick(1); check("bank_c_1ff", rd_data0, 8'h88);

      // Copy D interrupted by reset at address 50
      key0 = 8'h11;
      pulse_go0();
      wait_addr0(9'd50, 1000, "reach_50");
      #1 rst = 1'b1;
      #1;
      check("rst_mid_busrq", busrq0, 1'b0);
      check("rst_mid_busy", busy0, 1'b0);
      tick(2);
      rst = 1'b0;
      check("rst_mid_done", done0, 1'b0);
      rd_addr0 = 9'h1F3; tick(1); check("front0_1f3", rd_data0, 8'hC0);
      rd_addr0 = 9'd10;  tick(1); check("partial_10", rd_data0, 8'h1B);
      rd_addr0 = 9'd49;  tick(1); check("partial_49", rd_data0, 8'h20);
      rd_addr0 = 9'd50;  tick(1); check("untouched_50", rd_data0, 8'h01);
      rd_addr0 = 9'h1F3;
      tick(1);
      vblank0();
      check("no_swap_unready", rd_data0, 8'hC0);
      lvbl0 = 1'b1;
      tick(2);

      // Copy E restarts from address 0 after the reset
      key0 = 8'h11; a = acks0;
      pulse_go0();
      for (int n = 0; n < 200 && dma_addr0 == 9'd0; n++) tick(1);
      check("restart_addr", dma_addr0, 9'd1);
      wait_done0(5, 3000, "done_e");
      check("acks_e", acks0 - a, 513);
      rd_addr0 = 9'h1F3;
      tick(1);
      vblank0();
      check("swap_e_1f3", rd_data0, 8'hE2);
      lvbl0 = 1'b1;
      check_bank0(8'h11, "bank_e");

      // Single-bank 32x8 instance
      key1 = 8'hC3; a = acks1;
      pulse_go1();
      wait_done1(1, 2000, "done_s1");
      check("acks_s1", acks1 - a, 257);
      for (int k = 0; k < 256; k++) begin
         rd_addr1 = 8'(k);
         tick(1);
         check("bank_s1", rd_data1, 8'(k) ^ 8'hC3);
      end
      key1 = 8'h3C; a = acks1;
      rd_addr1 = 8'd5;
      pulse_go1();
      for (int n = 0; n < 200 && dma_addr1 != 8'd6; n++) tick(1);
      check("reach_6_s2", dma_addr1, 8'd6);
      check("same_addr_old", rd_data1, 8'hC6);
      tick(1);
      check("same_addr_new", rd_data1, 8'h39);
      wait_done1(2, 2000, "done_s2");
      check("acks_s2", acks1 - a, 257);
      rd_addr1 = 8'hFF;
      tick(1);
      check("bank_s2_ff", rd_data1, 8'hC3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
